instr_fetch_unit: RTL and testbench

//  Consumer end of the next-PC path: owns the architectural fetch PC, issues
//  in-order fetch requests to instruction memory and buffers returned words for

---
 rtl/instr_fetch_unit_pkg.sv | 23 ++
 rtl/instr_fetch_unit_fifo.sv | 65 ++++++
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-path types: datapath widths, fetch FSM encoding and buffer entry layout.
package instr_fetch_unit_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetchState_e;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetchEntry_t;

    function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Small synchronous {pc,instr} buffer between the fetch response path and decode.
module instr_fetch_unit_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          iClk,
    input  logic          iRstN,
    input  logic          iFlush,
    input  logic          iPush,
    input  fetchEntry_t   iData,
    input  logic          iPop,
    output fetchEntry_t   oHead,
    output logic          oFull,
    output logic          oEmpty,
    output logic [CW-1:0] oCount
);

    fetchEntry_t   mem [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] count;
    logic          doPush;
    logic          doPop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign doPush = iPush;
    assign doPop  = iPop && !oEmpty;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (iFlush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= nextPtr(wrPtr);
            if (doPop)  rdPtr <= nextPtr(rdPtr);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (doPush && !iFlush) mem[wrPtr] <= iData;
    end

    // Empty head reads as zero so decode never sees stale data.
    assign oHead  = oEmpty ? '0 : mem[rdPtr];
    assign oEmpty = (count == '0);
    assign oFull  = (count == CW'(DEPTH));
    assign oCount = count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC owner: issues in-order imem requests under a credit limit, buffers
// returned words for decode, and drops wrong-path responses after a redirect.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic               iClk,
    input  logic               iRstN,
    input  logic               iRedirect,
    input  logic [XLEN-1:0]    iRedirectPc,
    output logic               oImemReq,
    output logic [XLEN-1:0]    oImemAddr,
    input  logic               iImemGnt,
    input  logic               iImemRvalid,
    input  logic [INSTR_W-1:0] iImemRdata,
    output logic               oInstrValid,
    input  logic               iInstrReady,
    output logic [INSTR_W-1:0] oInstr,
    output logic [XLEN-1:0]    oInstrPc,
    output logic               oMisalign
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    fetchState_e     state;
    fetchState_e     stateNext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus4;
    logic [XLEN-1:0] rspPc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstandingNext;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   dropNext;
    logic [CW-1:0]   count;
    logic            grant;
    logic            push;
    logic            pop;
    logic            bufFull;
    logic            bufEmpty;
    logic            misalign;
    fetchEntry_t     pushData;
    fetchEntry_t     head;

    // Credit uses registered counts only; a same-cycle pop does not open a slot.
    assign oImemReq = (state == FETCH) && !iRedirect &&
                      (({1'b0, outstanding} + {1'b0, count}) < CREDITS);
    assign grant    = oImemReq && iImemGnt;
    assign pcPlus4  = pc + PC_STEP;

    // Live outstanding requests are contiguous, so the oldest one's address
    // is recovered from pc instead of queuing request PCs.
    assign rspPc    = pc - (XLEN'(outstanding) << 2);
    assign pushData = '{pc: rspPc, instr: iImemRdata};

    assign push = iImemRvalid && !iRedirect && (drop == '0);
    assign pop  = oInstrValid && iInstrReady && !iRedirect;

    assign outstandingNext = outstanding + CW'(grant) - CW'(iImemRvalid);

    always_comb begin
        dropNext = drop;
        if (iRedirect)
            dropNext = outstandingNext;
        else if (iImemRvalid && (drop != '0))
            dropNext = drop - CW'(1);
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = FETCH;
            FETCH:   if (iRedirect && (dropNext != '0)) stateNext = FLUSH;
            FLUSH:   if (!iRedirect && (dropNext == '0)) stateNext = FETCH;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            misalign    <= 1'b0;
        end else begin
            state       <= stateNext;
            outstanding <= outstandingNext;
            drop        <= dropNext;
            misalign    <= iRedirect && (iRedirectPc[1:0] != 2'b00);
            if (iRedirect)
                pc <= alignPc(iRedirectPc);
            else if (grant)
                pc <= pcPlus4;
            assert (!(push && bufFull));
        end
    end

    instr_fetch_unit_fifo #(.DEPTH(DEPTH)) uBuf (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iFlush (iRedirect),
        .iPush  (push),
        .iData  (pushData),
        .iPop   (pop),
        .oHead  (head),
        .oFull  (bufFull),
        .oEmpty (bufEmpty),
        .oCount (count)
    );

    assign oImemAddr   = pc;
    assign oInstrValid = !bufEmpty;
    assign oInstr      = head.instr;
    assign oInstrPc    = head.pc;
    assign oMisalign   = misalign;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; a simple in-order memory returns ~addr
// one cycle after each grant while rspEn is set.
module tb_instr_fetch_unit;

    logic        iClk;
    logic        iRstN;
    logic        iRedirect;
    logic [31:0] iRedirectPc;
    logic        oImemReq;
    logic [31:0] oImemAddr;
    logic        iImemGnt;
    logic        iImemRvalid;
    logic [31:0] iImemRdata;
    logic        oInstrValid;
    logic        iInstrReady;
    logic [31:0] oInstr;
    logic [31:0] oInstrPc;
    logic        oMisalign;

    int          nChecks;
    int          nErrors;
    int          nGrants;
    int          g0;
    int          w;
    logic        rspEn;
    logic        pendGnt;
    logic [31:0] pendAddr;
    logic [31:0] q[$];

    always begin
        iClk = 1'b0;
        #5;
        iClk = 1'b1;
        #5;
    end

    instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .iClk        (iClk),
        .iRstN       (iRstN),
        .iRedirect   (iRedirect),
        .iRedirectPc (iRedirectPc),
        .oImemReq    (oImemReq),
        .oImemAddr   (oImemAddr),
        .iImemGnt    (iImemGnt),
        .iImemRvalid (iImemRvalid),
        .iImemRdata  (iImemRdata),
        .oInstrValid (oInstrValid),
        .iInstrReady (iInstrReady),
        .oInstr      (oInstr),
        .oInstrPc    (oInstrPc),
        .oMisalign   (oMisalign)
    );

    // Memory: grants seen mid-cycle are queued at the edge; the head of the
    // queue is returned in the following cycle.
    always @(negedge iClk) begin
        pendGnt     = iRstN && oImemReq && iImemGnt;
        pendAddr    = oImemAddr;
        iImemRvalid = iRstN && rspEn && (q.size() > 0);
        iImemRdata  = (q.size() > 0) ? ~q[0] : 32'h0;
    end

    always @(posedge iClk) begin
        if (!iRstN) begin
            q.delete();
        end else begin
            if (iImemRvalid) void'(q.pop_front());
            if (pendGnt) begin
                q.push_back(pendAddr);
                nGrants++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    // Waits (bounded) for the next decode handoff and checks it; ready must be 1.
    task automatic expectInstr(input string tag, input logic [31:0] pc);
        int waited;
        waited = 0;
        while (!oInstrValid && waited < 20) begin
            cyc();
            waited++;
        end
        chk({tag, "_vld"}, 32'(oInstrValid), 32'd1);
        chk({tag, "_pc"}, oInstrPc, pc);
        chk({tag, "_data"}, oInstr, ~pc);
        cyc();
    endtask

    initial begin
        iRstN       = 1'b0;
        iRedirect   = 1'b0;
        iRedirectPc = 32'h0;
        iImemGnt    = 1'b0;
        iInstrReady = 1'b0;
        rspEn       = 1'b0;
        #2;
        chk("rst_req",   32'(oImemReq), 32'd0);
        chk("rst_addr",  oImemAddr, 32'h0);
        chk("rst_vld",   32'(oInstrValid), 32'd0);
        chk("rst_instr", oInstr, 32'h0);
        chk("rst_pc",    oInstrPc, 32'h0);
        chk("rst_ma",    32'(oMisalign), 32'd0);
        cyc();
        iRstN = 1'b1;
        #1;
        chk("idle_req", 32'(oImemReq), 32'd0);
        cyc();
        chk("fetch_req",  32'(oImemReq), 32'd1);
        chk("fetch_addr", oImemAddr, 32'h0);

        // straight-line fetch
        iImemGnt    = 1'b1;
        iInstrReady = 1'b1;
        rspEn       = 1'b1;
        expectInstr("s0", 32'h0);
        expectInstr("s4", 32'h4);
        expectInstr("s8", 32'h8);
        expectInstr("sC", 32'hC);

        // reset in the middle of streaming
        iRstN = 1'b0;
        #1;
        chk("mr_req",   32'(oImemReq), 32'd0);
        chk("mr_addr",  oImemAddr, 32'h0);
        chk("mr_vld",   32'(oInstrValid), 32'd0);
        chk("mr_instr", oInstr, 32'h0);
        chk("mr_pc",    oInstrPc, 32'h0);
        iImemGnt    = 1'b0;
        iInstrReady = 1'b0;
        cyc();
        cyc();
        iRstN = 1'b1;
        cyc();
        chk("mr_req_after", 32'(oImemReq), 32'd1);

        // backpressure: two credits, then request stalls
        g0       = nGrants;
        iImemGnt = 1'b1;
        repeat (5) cyc();
        chk("bp_grants", 32'(nGrants - g0), 32'd2);
        chk("bp_req",    32'(oImemReq), 32'd0);
        chk("bp_addr",   oImemAddr, 32'h8);
        chk("bp_vld",    32'(oInstrValid), 32'd1);
        chk("bp_pc",     oInstrPc, 32'h0);
        iInstrReady = 1'b1;
        expectInstr("r0", 32'h0);
        expectInstr("r4", 32'h4);
        expectInstr("r8", 32'h8);

        // redirect with two requests in flight
        rspEn = 1'b0;
        repeat (4) cyc();
        chk("rd_inflight_req", 32'(oImemReq), 32'd0);
        chk("rd_inflight_vld", 32'(oInstrValid), 32'd0);
        iRedirect   = 1'b1;
        iRedirectPc = 32'h100;
        cyc();
        iRedirect = 1'b0;
        chk("rd_addr",  oImemAddr, 32'h100);
        chk("rd_vld",   32'(oInstrValid), 32'd0);
        chk("rd_req",   32'(oImemReq), 32'd0);
        chk("rd_noma",  32'(oMisalign), 32'd0);
        rspEn = 1'b1;
        expectInstr("rd100", 32'h100);

        // misaligned redirect target
        iRedirect   = 1'b1;
        iRedirectPc = 32'h102;
        #1;
        chk("ma_req_kill", 32'(oImemReq), 32'd0);
        cyc();
        iRedirect = 1'b0;
        chk("ma_pulse", 32'(oMisalign), 32'd1);
        chk("ma_addr",  oImemAddr, 32'h100);
        chk("ma_vld",   32'(oInstrValid), 32'd0);
        cyc();
        chk("ma_pulse_end", 32'(oMisalign), 32'd0);
        expectInstr("ma100", 32'h100);
        expectInstr("ma104", 32'h104);

        // redirect while gnt is high and a response lands in the same cycle
        w = 0;
        while (q.size() == 0 && w < 10) begin
            cyc();
            w++;
        end
        chk("cn_rsp_pending", 32'(q.size() > 0), 32'd1);
        iRedirect   = 1'b1;
        iRedirectPc = 32'h40;
        cyc();
        iRedirect = 1'b0;
        chk("cn_addr", oImemAddr, 32'h40);
        chk("cn_vld",  32'(oInstrValid), 32'd0);
        expectInstr("cn40", 32'h40);
        expectInstr("cn44", 32'h44);

        // PC wrap at the top of the address space
        iRedirect   = 1'b1;
        iRedirectPc = 32'hFFFF_FFFC;
        cyc();
        iRedirect = 1'b0;
        chk("wr_addr", oImemAddr, 32'hFFFF_FFFC);
        expectInstr("wrFC", 32'hFFFF_FFFC);
        expectInstr("wr0",  32'h0);
        expectInstr("wr4",  32'h4);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
